isp_csc_arb: RTL and testbench
==============================

Name: isp_csc_arb

Overview:
Frame-granular round-robin arbiter that shares one isp_csc RGB-to-gray pipeline between two RGB pixel sources. It grants the pipeline to one source for one whole frame. It forwards that source's pixels into the CSC, counts pixels in flight, and routes CSC results back to the owning source. Ownership switches only after the frame's last pixel has drained out of the CSC. It sits between the two camera/DMA pixel streams and the shared isp_csc instance feeding the Sobel stages.

Parameters:
MAX_INFLIGHT, 4, maximum pixels allowed inside the CSC at once (CSC holds at most 4: two skid stages of depth 2)
CNT_W, 3, width of the in-flight counter; must satisfy 2^CNT_W > MAX_INFLIGHT

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
arb_en  in  1  1 = new grants allowed; 0 = finish the current frame, then stay idle
s0_valid  in  1  source 0 pixel valid
s0_ready  out  1  source 0 pixel ready
s0_rgb  in  24  source 0 pixel {R,G,B}
s0_last  in  1  source 0 last pixel of frame
s1_valid, s1_ready, s1_rgb, s1_last  (same widths/directions as s0_*)  source 1
csc_valid  out  1  to CSC valid_m
csc_ready  in  1  from CSC ready_m
csc_rgb  out  24  to CSC data_m_rgb
csc_valid_s  in  1  from CSC valid_s
csc_ready_s  out  1  to CSC ready_s
csc_gray  in  8  from CSC data_s_gray
csc_rgb_s  in  24  from CSC data_s_rgb
r0_valid  out  1  result valid to source 0
r0_ready  in  1  result ready from source 0
r0_gray  out  8  gray result
r0_rgb  out  24  bypassed RGB
r0_last  out  1  last result of frame
r1_valid, r1_ready, r1_gray, r1_rgb, r1_last  (same as r0_*)  result port for source 1
busy  out  1  state != IDLE
owner  out  1  current or most recent grant holder
frame_done  out  2  one-cycle pulse per source when its frame has fully drained

Behaviour:
- Reset (async, rst_n=0): state=IDLE, inflight=0, owner=0, last_owner=1 (so source 0 wins first), all valid/ready outputs 0, frame_done=0, busy=0.
- FSM states: IDLE, BUSY, DRAIN.
- IDLE:
  - Pixel and result paths are closed: s*_ready=0, csc_valid=0, csc_ready_s=0.
  - If arb_en and any sN_valid: winner = the requester that is not last_owner when both request, otherwise the single requester.
  - owner<=winner and state<=BUSY on the next edge. Grant latency is 1 cycle, and no pixel is forwarded in the IDLE cycle.
- BUSY (owner=k):
  - csc_rgb = sk_rgb.
  - csc_valid = sk_valid && (inflight < MAX_INFLIGHT).
  - sk_ready = csc_ready && (inflight < MAX_INFLIGHT).
  - The non-owner's ready is held at 0.
  - Accepting a beat (csc_valid && csc_ready) with sk_last=1 moves state to DRAIN.
- Return path in BUSY and DRAIN:
  - rk_valid = csc_valid_s; csc_ready_s = rk_ready; rk_gray/rk_rgb = csc_gray/csc_rgb_s.
  - The non-owner's r_valid is 0. Result data is don't-care when valid=0.
- inflight counter:
  - +1 on accept, -1 on return (csc_valid_s && csc_ready_s).
  - Simultaneous accept and return: counter unchanged.
  - Never exceeds MAX_INFLIGHT and never underflows; a return while inflight=0 is an assertion error.
- DRAIN:
  - No new pixels are accepted; s*_ready=0.
  - rk_last = 1 on the return beat where inflight==1.
  - That beat's transfer takes the state to IDLE, pulses frame_done[k] for 1 cycle, and sets last_owner<=k.
- r_last is 0 in every other state and beat.
- Single-pixel frame: BUSY accepts last, goes to DRAIN; inflight=1, so the first return is flagged last.
- Last pixel accepted while returns are still pending: the count includes the last pixel itself, so r_last marks exactly the frame's final result.
- Back-to-back frames from the same source when the other is idle: IDLE is re-entered for one cycle (one bubble), then the same source is re-granted.
- arb_en=0 during BUSY/DRAIN: the current frame completes normally, then the FSM stays in IDLE.
- Reset mid-frame: everything clears immediately. The CSC shares rst_n, so in-flight pixels are discarded with no partial r_last.
- owner holds its value in IDLE; busy is combinational from state.

Test Plan:
- Only s0 streams a 4-pixel frame; pixels are 0xFF0000, 0x00FF00, 0x0000FF, 0xFFFFFF with last on the 4th; ready high -> r0 gets gray 0x4C, 0x95, 0x1C, 0xFF with r0_last on the 4th beat only; frame_done[0] pulses once; r1_valid stays 0.
- Both sources valid from reset -> s0 granted first. After frame_done[0], s1 is granted. With both still requesting, grants alternate s0, s1, s0, s1.
- s0 frame with r0_ready=0 for 20 cycles -> at most 4 pixels are accepted; s0_ready drops; inflight=4. After r0_ready rises, all results arrive in order with no loss.
- Single-pixel frame (s1_last on the first beat) -> one r1 beat with r1_last=1; frame_done[1] pulses; FSM passes BUSY->DRAIN->IDLE.
- arb_en dropped mid-frame -> the current frame completes with frame_done; no further grant while arb_en=0; the grant resumes 1 cycle after arb_en=1.
- rst_n asserted with 3 pixels in flight -> all outputs are 0 immediately; inflight=0. After release, s0 (last_owner=1) wins the next grant.

Source files
------------

// File: rtl/isp_csc_arb.sv
// Frame-granular round-robin arbiter in front of a shared isp_csc instance.
// One source owns the CSC per frame; ownership moves only after its last result drains.
module isp_csc_arb #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arb_en,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [23:0] s0_rgb,
    input  logic        s0_last,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [23:0] s1_rgb,
    input  logic        s1_last,
    output logic        csc_valid,
    input  logic        csc_ready,
    output logic [23:0] csc_rgb,
    input  logic        csc_valid_s,
    output logic        csc_ready_s,
    input  logic [7:0]  csc_gray,
    input  logic [23:0] csc_rgb_s,
    output logic        r0_valid,
    input  logic        r0_ready,
    output logic [7:0]  r0_gray,
    output logic [23:0] r0_rgb,
    output logic        r0_last,
    output logic        r1_valid,
    input  logic        r1_ready,
    output logic [7:0]  r1_gray,
    output logic [23:0] r1_rgb,
    output logic        r1_last,
    output logic        busy,
    output logic        owner,
    output logic [1:0]  frame_done
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    logic             last_owner;
    logic [CNT_W-1:0] inflight;
    logic             room, own_valid, own_last, own_rdy_s;
    logic             acc, ret, res_last, drain_end, winner;

    assign room      = inflight < MAX_CNT;
    assign own_valid = owner ? s1_valid : s0_valid;
    assign own_last  = owner ? s1_last  : s0_last;
    assign own_rdy_s = owner ? r1_ready : r0_ready;

    // Forward path: only the owner is connected, and only while BUSY.
    assign csc_valid = (state == BUSY) && own_valid && room;
    assign csc_rgb   = owner ? s1_rgb : s0_rgb;
    assign s0_ready  = (state == BUSY) && !owner && csc_ready && room;
    assign s1_ready  = (state == BUSY) &&  owner && csc_ready && room;
    assign acc       = csc_valid && csc_ready;

    // Return path stays open through DRAIN so the tail of the frame can leave.
    assign csc_ready_s = (state != IDLE) && own_rdy_s;
    assign ret         = csc_valid_s && csc_ready_s;
    assign res_last    = (state == DRAIN) && (inflight == ONE);
    assign drain_end   = res_last && ret;

    assign r0_valid = (state != IDLE) && !owner && csc_valid_s;
    assign r1_valid = (state != IDLE) &&  owner && csc_valid_s;
    assign r0_last  = r0_valid && res_last;
    assign r1_last  = r1_valid && res_last;
    assign r0_gray  = csc_gray;
    assign r1_gray  = csc_gray;
    assign r0_rgb   = csc_rgb_s;
    assign r1_rgb   = csc_rgb_s;

    assign busy   = (state != IDLE);
    assign winner = (s0_valid && s1_valid) ? ~last_owner : s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            inflight   <= '0;
            frame_done <= '0;
        end else begin
            frame_done <= '0;
            case (state)
                IDLE: if (arb_en && (s0_valid || s1_valid)) begin
                    owner <= winner;
                    state <= BUSY;
                end
                BUSY: if (acc && own_last) state <= DRAIN;
                DRAIN: if (drain_end) begin
                    state      <= IDLE;
                    last_owner <= owner;
                    frame_done <= owner ? 2'b10 : 2'b01;
                end
                default: state <= IDLE;
            endcase
            // Simultaneous accept and return leaves the count unchanged.
            case ({acc, ret})
                2'b10:   inflight <= inflight + ONE;
                2'b01:   inflight <= inflight - ONE;
                default: inflight <= inflight;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(ret && inflight == '0));
    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) inflight <= MAX_CNT);

endmodule

// File: tb/tb_isp_csc_arb.sv
// Directed bench for isp_csc_arb with a 4-entry CSC model (gray = (77R+150G+29B)>>8).
module tb_isp_csc_arb;
    logic        clk, rst_n, arb_en;
    logic        s0_valid, s0_ready, s0_last, s1_valid, s1_ready, s1_last;
    logic [23:0] s0_rgb, s1_rgb, csc_rgb, csc_rgb_s, r0_rgb, r1_rgb;
    logic        csc_valid, csc_ready, csc_valid_s, csc_ready_s;
    logic [7:0]  csc_gray, r0_gray, r1_gray;
    logic        r0_valid, r0_ready, r0_last, r1_valid, r1_ready, r1_last;
    logic        busy, owner;
    logic [1:0]  frame_done;

    int n_run = 0, n_fail = 0;

    isp_csc_arb dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rgb(s0_rgb), .s0_last(s0_last),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rgb(s1_rgb), .s1_last(s1_last),
        .csc_valid(csc_valid), .csc_ready(csc_ready), .csc_rgb(csc_rgb),
        .csc_valid_s(csc_valid_s), .csc_ready_s(csc_ready_s), .csc_gray(csc_gray), .csc_rgb_s(csc_rgb_s),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_gray(r0_gray), .r0_rgb(r0_rgb), .r0_last(r0_last),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_gray(r1_gray), .r1_rgb(r1_rgb), .r1_last(r1_last),
        .busy(busy), .owner(owner), .frame_done(frame_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // CSC model: 4-deep FIFO sharing rst_n, results visible one cycle after accept.
    logic [23:0] cmem [4];
    logic [1:0]  cwr, crd;
    logic [2:0]  ccnt;
    logic [23:0] chead;
    assign chead       = cmem[crd];
    assign csc_ready   = (ccnt < 3'd4);
    assign csc_valid_s = (ccnt != 3'd0);
    assign csc_rgb_s   = chead;
    assign csc_gray    = 8'((77 * int'(chead[23:16]) + 150 * int'(chead[15:8]) + 29 * int'(chead[7:0])) >> 8);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cwr <= '0; crd <= '0; ccnt <= '0;
        end else begin
            if (csc_valid && csc_ready) begin
                cmem[cwr] <= csc_rgb;
                cwr <= cwr + 2'd1;
            end
            if (csc_valid_s && csc_ready_s) crd <= crd + 2'd1;
            ccnt <= ccnt + 3'((csc_valid && csc_ready) ? 1 : 0) - 3'((csc_valid_s && csc_ready_s) ? 1 : 0);
        end
    end

    // Monitor: sole writer of result queues and event counters.
    logic [32:0] q0[$], q1[$];
    int done_log[$];
    int fd0_cnt = 0, fd1_cnt = 0, acc0 = 0, infl = 0, max_infl = 0;
    always @(negedge clk) begin
        if (!rst_n) infl = 0;
        else begin
            if (r0_valid && r0_ready) q0.push_back({r0_last, r0_rgb, r0_gray});
            if (r1_valid && r1_ready) q1.push_back({r1_last, r1_rgb, r1_gray});
            if (frame_done[0]) begin fd0_cnt++; done_log.push_back(0); end
            if (frame_done[1]) begin fd1_cnt++; done_log.push_back(1); end
            if (s0_valid && s0_ready) acc0++;
            if (csc_valid && csc_ready) infl++;
            if (csc_valid_s && csc_ready_s) infl--;
            if (infl > max_infl) max_infl = infl;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fd(input int src, input int target, input string tag);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if ((src == 1 ? fd1_cnt : fd0_cnt) >= target) begin ok = 1; break; end
        end
        chk({tag, "_timeout"}, 64'(ok), 64'd1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    logic [24:0] tx0[$], tx1[$];
    int b0, b1, bd, bf0, bf1, ba;

    initial begin
        rst_n = 0; arb_en = 1; r0_ready = 1; r1_ready = 1;
        s0_valid = 0; s0_rgb = '0; s0_last = 0;
        s1_valid = 0; s1_rgb = '0; s1_last = 0;
        fork
            forever begin : drv0
                bit f;
                @(negedge clk); f = s0_valid && s0_ready && rst_n;
                @(posedge clk); if (f && tx0.size() > 0) void'(tx0.pop_front());
                #1;
                if (tx0.size() > 0) begin s0_valid = 1; {s0_last, s0_rgb} = tx0[0]; end
                else begin s0_valid = 0; s0_last = 0; s0_rgb = '0; end
            end
            forever begin : drv1
                bit f;
                @(negedge clk); f = s1_valid && s1_ready && rst_n;
                @(posedge clk); if (f && tx1.size() > 0) void'(tx1.pop_front());
                #1;
                if (tx1.size() > 0) begin s1_valid = 1; {s1_last, s1_rgb} = tx1[0]; end
                else begin s1_valid = 0; s1_last = 0; s1_rgb = '0; end
            end
        join_none

        // Reset state
        cycles(2);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'({s0_ready, s1_ready, csc_valid, csc_ready_s}), 64'd0);
        chk("rst_rvalid", 64'({r0_valid, r1_valid}), 64'd0);
        chk("rst_owner_fd", 64'({owner, frame_done}), 64'd0);
        @(posedge clk); #1 rst_n = 1;

        // 4-pixel frame from s0 only
        cycles(2);
        b0 = q0.size(); b1 = q1.size(); bf0 = fd0_cnt;
        tx0.push_back({1'b0, 24'hFF0000}); tx0.push_back({1'b0, 24'h00FF00});
        tx0.push_back({1'b0, 24'h0000FF}); tx0.push_back({1'b1, 24'hFFFFFF});
        wait_fd(0, bf0 + 1, "t1_fd");
        cycles(5);
        chk("t1_count", 64'(q0.size() - b0), 64'd4);
        chk("t1_gray0", 64'(q0[b0][7:0]), 64'h4C);
        chk("t1_gray1", 64'(q0[b0+1][7:0]), 64'h95);
        chk("t1_gray2", 64'(q0[b0+2][7:0]), 64'h1C);
        chk("t1_gray3", 64'(q0[b0+3][7:0]), 64'hFF);
        chk("t1_rgb3", 64'(q0[b0+3][31:8]), 64'hFFFFFF);
        chk("t1_lasts", 64'({q0[b0][32], q0[b0+1][32], q0[b0+2][32], q0[b0+3][32]}), 64'b0001);
        chk("t1_fd_once", 64'(fd0_cnt - bf0), 64'd1);
        chk("t1_no_r1", 64'(q1.size() - b1), 64'd0);

        // Both sources requesting from reset: grants alternate starting with s0
        @(posedge clk); #1 rst_n = 0;
        tx0.push_back({1'b0, 24'h101010}); tx0.push_back({1'b1, 24'h202020});
        tx0.push_back({1'b0, 24'h303030}); tx0.push_back({1'b1, 24'h404040});
        tx1.push_back({1'b0, 24'h505050}); tx1.push_back({1'b1, 24'h606060});
        tx1.push_back({1'b0, 24'h707070}); tx1.push_back({1'b1, 24'h808080});
        b0 = q0.size(); b1 = q1.size(); bd = done_log.size(); bf0 = fd0_cnt; bf1 = fd1_cnt;
        cycles(2); #1 rst_n = 1;
        wait_fd(0, bf0 + 2, "t2_fd0");
        wait_fd(1, bf1 + 2, "t2_fd1");
        cycles(3);
        chk("t2_order", 64'({4'(done_log[bd]), 4'(done_log[bd+1]), 4'(done_log[bd+2]), 4'(done_log[bd+3])}), 64'h0101);
        chk("t2_r0_gray", 64'({q0[b0][7:0], q0[b0+1][7:0], q0[b0+2][7:0], q0[b0+3][7:0]}), 64'h10203040);
        chk("t2_r1_gray", 64'({q1[b1][7:0], q1[b1+1][7:0], q1[b1+2][7:0], q1[b1+3][7:0]}), 64'h50607080);
        chk("t2_r0_last", 64'({q0[b0][32], q0[b0+1][32], q0[b0+2][32], q0[b0+3][32]}), 64'b0101);
        chk("t2_r1_last", 64'({q1[b1][32], q1[b1+1][32], q1[b1+2][32], q1[b1+3][32]}), 64'b0101);

        // Result backpressure: CSC fills to 4, then everything drains in order
        @(posedge clk); #1 r0_ready = 0;
        b0 = q0.size(); ba = acc0; bf0 = fd0_cnt;
        for (int i = 1; i <= 6; i++) tx0.push_back({(i == 6), 24'(i * 24'h010101)});
        cycles(20);
        chk("t3_accepted", 64'(acc0 - ba), 64'd4);
        chk("t3_inflight", 64'(infl), 64'd4);
        @(negedge clk);
        chk("t3_s0_ready", 64'({s0_ready, csc_valid}), 64'd0);
        @(posedge clk); #1 r0_ready = 1;
        wait_fd(0, bf0 + 1, "t3_fd");
        cycles(2);
        chk("t3_count", 64'(q0.size() - b0), 64'd6);
        chk("t3_gray", 64'({q0[b0][7:0], q0[b0+1][7:0], q0[b0+2][7:0], q0[b0+3][7:0], q0[b0+4][7:0], q0[b0+5][7:0]}), 64'h010203040506);
        chk("t3_last", 64'({q0[b0][32], q0[b0+1][32], q0[b0+2][32], q0[b0+3][32], q0[b0+4][32], q0[b0+5][32]}), 64'b000001);
        chk("t3_max_infl", 64'(max_infl), 64'd4);

        // Single-pixel frame on s1
        b1 = q1.size(); bf1 = fd1_cnt;
        tx1.push_back({1'b1, 24'hC0C0C0});
        wait_fd(1, bf1 + 1, "t4_fd");
        cycles(2);
        chk("t4_count", 64'(q1.size() - b1), 64'd1);
        chk("t4_beat", 64'({q1[b1][32], q1[b1][7:0]}), 64'h1C0);
        chk("t4_fd_once", 64'(fd1_cnt - bf1), 64'd1);
        @(negedge clk);
        chk("t4_idle", 64'(busy), 64'd0);

        // arb_en dropped mid-frame: frame finishes, no new grant until re-enabled
        b0 = q0.size(); b1 = q1.size(); bf0 = fd0_cnt; bf1 = fd1_cnt; ba = acc0;
        for (int i = 1; i <= 4; i++) tx0.push_back({(i == 4), 24'(24'h202020 + i * 24'h010101)});
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (acc0 != ba) break;
        end
        #1 arb_en = 0;
        tx1.push_back({1'b1, 24'h303030});
        wait_fd(0, bf0 + 1, "t5_fd0");
        cycles(10);
        chk("t5_r0_count", 64'(q0.size() - b0), 64'd4);
        chk("t5_r0_last", 64'({q0[b0+3][32], q0[b0+3][7:0]}), 64'h124);
        chk("t5_no_grant", 64'({fd1_cnt - bf1, q1.size() - b1}), 64'd0);
        @(negedge clk);
        chk("t5_held_idle", 64'({busy, s1_ready}), 64'd0);
        @(posedge clk); #1 arb_en = 1;
        @(negedge clk);
        chk("t5_grant_cycle", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t5_granted", 64'({busy, owner}), 64'b11);
        wait_fd(1, bf1 + 1, "t5_fd1");

        // Reset with 3 pixels in flight
        @(posedge clk); #1 r0_ready = 0;
        for (int i = 1; i <= 5; i++) tx0.push_back({(i == 5), 24'(24'h404040 + i * 24'h010101)});
        begin
            bit hit = 0;
            for (int i = 0; i < 50; i++) begin
                @(posedge clk);
                if (infl == 3) begin hit = 1; break; end
            end
            chk("t6_reach3", 64'(hit), 64'd1);
        end
        #2 rst_n = 0;
        #1;
        chk("t6_busy", 64'({busy, owner, frame_done}), 64'd0);
        chk("t6_paths", 64'({s0_ready, s1_ready, csc_valid, csc_ready_s, r0_valid, r1_valid, r0_last}), 64'd0);
        chk("t6_inflight", 64'(dut.inflight), 64'd0);
        tx0.delete(); tx1.delete();
        cycles(1);
        tx0.push_back({1'b1, 24'h111111});
        tx1.push_back({1'b1, 24'h222222});
        r0_ready = 1;
        bd = done_log.size(); b0 = q0.size(); bf1 = fd1_cnt;
        cycles(2); #1 rst_n = 1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_regrant", 64'({busy, owner}), 64'b10);
        wait_fd(1, bf1 + 1, "t6_fd1");
        cycles(2);
        chk("t6_first", 64'(done_log[bd]), 64'd0);
        chk("t6_r0", 64'({q0.size() - b0, q0[b0][7:0]}), 64'h1_11);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
